// File: rtl/matmul_seq_param.sv
`default_nettype none
// ============================================================================
// Module      : matmul_seq_param
// Description : Sequential N x N matrix multiplier (Result = A x B) built
//               around a single multiply-accumulate unit. Start/done
//               handshake, signed/unsigned operands, saturating or
//               truncating result conversion, synchronous abort.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_seq_param #(
  parameter int N      = 3,
  parameter int W      = 16,
  parameter int ACC_W  = 36,
  parameter int OUT_W  = 16,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [N*N*W-1:0]       a,
  input  logic [N*N*W-1:0]       b,
  output logic [N*N*OUT_W-1:0]   result,
  output logic                   done,
  output logic                   busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int NE = N * N;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Clamp bounds expressed at accumulator width
  localparam logic [ACC_W-1:0] UMAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic [ACC_W-1:0] SMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t               state;
  logic [N*N*W-1:0]     a_q;
  logic [N*N*W-1:0]     b_q;
  logic [ACC_W-1:0]     acc [NE];
  logic [CW-1:0]        i_q;
  logic [CW-1:0]        j_q;
  logic [CW-1:0]        k_q;

  int                   a_idx;
  int                   b_idx;
  int                   c_idx;
  logic [W-1:0]         a_el;
  logic [W-1:0]         b_el;
  logic [2*W-1:0]       a_ext;
  logic [2*W-1:0]       b_ext;
  logic [2*W-1:0]       prod;
  logic [ACC_W-1:0]     prod_ext;
  logic [N*N*OUT_W-1:0] conv;

  // Select A[i][k], B[k][j] and form the full-width product extended to ACC_W.
  // Operands are extended to 2W first; the low 2W bits of that product are
  // the exact signed or unsigned product.
  always_comb begin
    a_idx = int'(i_q) * N + int'(k_q);
    b_idx = int'(k_q) * N + int'(j_q);
    c_idx = int'(i_q) * N + int'(j_q);
    a_el  = a_q[a_idx*W +: W];
    b_el  = b_q[b_idx*W +: W];
    if (SIGNED != 0) begin
      a_ext = {{W{a_el[W-1]}}, a_el};
      b_ext = {{W{b_el[W-1]}}, b_el};
    end else begin
      a_ext = {{W{1'b0}}, a_el};
      b_ext = {{W{1'b0}}, b_el};
    end
    prod = a_ext * b_ext;
    if (SIGNED != 0) begin
      prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    end else begin
      prod_ext = {{(ACC_W-2*W){1'b0}}, prod};
    end
  end

  // Per-element conversion from accumulator width to result width
  for (genvar e = 0; e < NE; e++) begin : g_conv
    if (SAT == 0) begin : g_trunc
      assign conv[e*OUT_W +: OUT_W] = acc[e][OUT_W-1:0];
    end else if (SIGNED != 0) begin : g_ssat
      assign conv[e*OUT_W +: OUT_W] =
        ($signed(acc[e]) > $signed(SMAX)) ? SMAX[OUT_W-1:0] :
        ($signed(acc[e]) < $signed(SMIN)) ? SMIN[OUT_W-1:0] :
                                            acc[e][OUT_W-1:0];
    end else begin : g_usat
      assign conv[e*OUT_W +: OUT_W] =
        (acc[e] > UMAX) ? UMAX[OUT_W-1:0] : acc[e][OUT_W-1:0];
    end
  end

  // Control FSM, operand capture, MAC accumulation and result load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      for (int e = 0; e < NE; e++) begin
        acc[e] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // abort is irrelevant here, so start always wins
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            for (int e = 0; e < NE; e++) begin
              acc[e] <= '0;
            end
            state <= S_MAC;
            busy  <= 1'b1;
          end
        end
        S_MAC: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            acc[c_idx] <= acc[c_idx] + prod_ext;
            if (k_q == LAST) begin
              k_q <= '0;
              if (j_q == LAST) begin
                j_q <= '0;
                if (i_q == LAST) begin
                  i_q   <= '0;
                  state <= S_WRITE;
                end else begin
                  i_q <= i_q + 1'b1;
                end
              end else begin
                j_q <= j_q + 1'b1;
              end
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        S_WRITE: begin
          // abort suppresses the load so Result keeps the previous product
          state <= S_IDLE;
          busy  <= 1'b0;
          if (!abort) begin
            result <= conv;
            done   <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul_seq_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_seq_param
// Description : Self-checking bench for matmul_seq_param. Default 3x3
//               unsigned instance plus 2x2 signed saturating / truncating
//               instances driven side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_seq_param;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  // Default instance (N=3, W=16, OUT_W=16, unsigned, truncating)
  logic         start3 = 1'b0;
  logic         abort3 = 1'b0;
  logic [143:0] a3 = '0;
  logic [143:0] b3 = '0;
  logic [143:0] res3;
  logic         done3;
  logic         busy3;

  // 2x2 signed instances (saturating and truncating) sharing stimulus
  logic         start2 = 1'b0;
  logic         abort2 = 1'b0;
  logic [31:0]  a2 = '0;
  logic [31:0]  b2 = '0;
  logic [31:0]  res_s;
  logic [31:0]  res_t;
  logic         done_s;
  logic         done_t;
  logic         busy_s;
  logic         busy_t;

  int n_cmp = 0;
  int n_bad = 0;

  matmul_seq_param dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .a(a3), .b(b3), .result(res3), .done(done3), .busy(busy3)
  );

  matmul_seq_param #(.N(2), .W(8), .ACC_W(20), .OUT_W(8), .SIGNED(1), .SAT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .a(a2), .b(b2), .result(res_s), .done(done_s), .busy(busy_s)
  );

  matmul_seq_param #(.N(2), .W(8), .ACC_W(20), .OUT_W(8), .SIGNED(1), .SAT(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .a(a2), .b(b2), .result(res_t), .done(done_t), .busy(busy_t)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [143:0] pack3(input int e0, input int e1, input int e2,
                                         input int e3, input int e4, input int e5,
                                         input int e6, input int e7, input int e8);
    int           e [9];
    logic [143:0] r;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    e[5] = e5; e[6] = e6; e[7] = e7; e[8] = e8;
    r = '0;
    for (int k = 0; k < 9; k++) r[k*16 +: 16] = e[k][15:0];
    return r;
  endfunction

  function automatic logic [31:0] pack2(input int e0, input int e1, input int e2, input int e3);
    logic [31:0] r;
    r[7:0]   = e0[7:0];
    r[15:8]  = e1[7:0];
    r[23:16] = e2[7:0];
    r[31:24] = e3[7:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done3(output int lat);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (done3) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic count_done3(input int cyc, output int n);
    n = 0;
    for (int c = 0; c < cyc; c++) begin
      tick();
      if (done3) n++;
    end
  endtask

  // Present operands with a one-cycle start; returns just after the accepting edge
  task automatic launch3(input logic [143:0] av, input logic [143:0] bv);
    a3 = av;
    b3 = bv;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    a3 = ~av;
    b3 = ~bv;
  endtask

  typedef struct {
    logic [143:0] a;
    logic [143:0] b;
    logic [143:0] exp;
  } v3_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_sat;
    logic [31:0] exp_trunc;
  } v2_t;

  v3_t t3 [4];
  v2_t t2 [3];

  initial begin
    logic [143:0] m_a, m_i, m_sq, m_zero, m_max;
    int lat, n;

    m_a    = pack3(1, 2, 3, 4, 5, 6, 7, 8, 9);
    m_i    = pack3(1, 0, 0, 0, 1, 0, 0, 0, 1);
    m_sq   = pack3(30, 36, 42, 66, 81, 96, 102, 126, 150);
    m_zero = '0;
    m_max  = pack3(65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535);

    t3[0] = '{a: m_a,   b: m_i,    exp: m_a};
    t3[1] = '{a: m_a,   b: m_a,    exp: m_sq};
    t3[2] = '{a: m_a,   b: m_zero, exp: m_zero};
    t3[3] = '{a: m_max, b: m_max,  exp: pack3(3, 3, 3, 3, 3, 3, 3, 3, 3)};

    t2[0] = '{a: pack2(127, 127, 127, 127), b: pack2(127, 127, 127, 127),
              exp_sat: pack2(127, 127, 127, 127), exp_trunc: pack2(2, 2, 2, 2)};
    t2[1] = '{a: pack2(-128, -128, -128, -128), b: pack2(127, 127, 127, 127),
              exp_sat: pack2(-128, -128, -128, -128), exp_trunc: pack2(0, 0, 0, 0)};
    t2[2] = '{a: pack2(1, -2, 3, 4), b: pack2(5, 6, -7, 8),
              exp_sat: pack2(19, -10, -13, 50), exp_trunc: pack2(19, -10, -13, 50)};

    // Reset state
    #1;
    chk("reset result3", res3, 0);
    chk("reset busy3", busy3, 0);
    chk("reset done3", done3, 0);
    chk("reset result_sat", res_s, 0);
    #20;
    rst_n = 1'b1;
    tick();

    // Table-driven runs on the default instance
    for (int v = 0; v < 4; v++) begin
      launch3(t3[v].a, t3[v].b);
      chk($sformatf("v%0d busy after start", v), busy3, 1);
      wait_done3(lat);
      chk($sformatf("v%0d latency", v), lat, 28);
      chk($sformatf("v%0d busy in done cycle", v), busy3, 0);
      chk($sformatf("v%0d result", v), res3, t3[v].exp);
      tick();
      chk($sformatf("v%0d done one cycle", v), done3, 0);
    end

    // Table-driven runs on the 2x2 signed instances
    for (int v = 0; v < 3; v++) begin
      a2 = t2[v].a;
      b2 = t2[v].b;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      a2 = '0;
      b2 = '0;
      lat = -1;
      for (int c = 1; c <= 30; c++) begin
        tick();
        if (done_s) begin
          lat = c;
          break;
        end
      end
      chk($sformatf("n2 v%0d latency", v), lat, 9);
      chk($sformatf("n2 v%0d trunc done aligned", v), done_t, 1);
      chk($sformatf("n2 v%0d sat result", v), res_s, t2[v].exp_sat);
      chk($sformatf("n2 v%0d trunc result", v), res_t, t2[v].exp_trunc);
      tick();
    end

    // start pulsed while busy is ignored
    launch3(m_a, m_a);
    for (int c = 0; c < 4; c++) tick();
    a3 = m_i;
    b3 = m_i;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    wait_done3(lat);
    chk("busy-start latency", lat, 23);
    chk("busy-start result", res3, m_sq);
    count_done3(40, n);
    chk("busy-start no extra done", n, 0);

    // start held in the done cycle is accepted immediately
    launch3(m_a, m_i);
    wait_done3(lat);
    chk("b2b first latency", lat, 28);
    chk("b2b first result", res3, m_a);
    a3 = m_a;
    b3 = m_a;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    chk("b2b second busy", busy3, 1);
    wait_done3(lat);
    chk("b2b second latency", lat, 28);
    chk("b2b second result", res3, m_sq);
    tick();

    // abort mid-MAC
    launch3(m_i, m_i);
    for (int c = 0; c < 9; c++) tick();
    abort3 = 1'b1;
    tick();
    chk("abort busy low", busy3, 0);
    abort3 = 1'b0;
    count_done3(40, n);
    chk("abort no done", n, 0);
    chk("abort result kept", res3, m_sq);

    // abort and start together in IDLE: start wins
    a3 = m_i;
    b3 = m_i;
    start3 = 1'b1;
    abort3 = 1'b1;
    tick();
    start3 = 1'b0;
    abort3 = 1'b0;
    chk("start+abort busy", busy3, 1);
    wait_done3(lat);
    chk("start+abort latency", lat, 28);
    chk("start+abort result", res3, m_i);
    tick();

    // asynchronous reset mid-operation
    launch3(m_a, m_a);
    for (int c = 0; c < 15; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset result", res3, 0);
    chk("async reset busy", busy3, 0);
    chk("async reset done", done3, 0);
    #3;
    rst_n = 1'b1;
    count_done3(40, n);
    chk("after reset no done", n, 0);
    chk("after reset busy", busy3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matmul_seq_param.md
Name: matmul_seq_param

Overview:
- Parametrised sequential N x N matrix multiplier, Result = A x B, using one multiply-accumulate (MAC) unit.
- Successor to the fixed 3x3/16-bit calculator. Adds:
  - clocked operation with a start/done handshake;
  - configurable dimension and widths;
  - signed/unsigned arithmetic;
  - saturating or truncating output;
  - synchronous abort.
- Sits as a compute slave behind a controller that presents flat operand buses and waits for done.

Parameters:
- N, default 3: matrix dimension; legal range 2..16.
- W, default 16: operand element width in bits.
- ACC_W, default 36: accumulator width; must be >= 2*W + ceil(log2 N).
- OUT_W, default 16: result element width in bits.
- SIGNED, default 0: 1 = two's-complement operands and results; 0 = unsigned.
- SAT, default 0: 1 = clamp each result element to the OUT_W range; 0 = keep the low OUT_W bits.

Ports:
- Clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request; sampled only in IDLE.
- abort  input  1  synchronous cancel of an operation in progress.
- A  input  N*N*W  operand A, row-major; element [i][j] at bits (i*N+j)*W +: W.
- B  input  N*N*W  operand B, same layout as A.
- Result  output  N*N*OUT_W  product, row-major; element [i][j] at bits (i*N+j)*OUT_W +: OUT_W.
- done  output  1  one-cycle pulse; Result is valid from this cycle onward.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE;
  - Result=0, done=0, busy=0;
  - internal A/B copies, accumulator, i/j/k counters cleared.
  - Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, MAC, WRITE.
- IDLE:
  - if start=1 at edge t: latch A and B into internal arrays, clear the accumulator array, set i=j=k=0, go to MAC.
  - A/B may change freely after edge t.
- MAC:
  - one MAC per cycle: acc[i][j] += A[i][k]*B[k][j].
  - product is the full 2W-bit value, sign- or zero-extended to ACC_W per SIGNED.
  - counter order: k fastest, then j, then i. k wraps at N-1 and increments j; j wraps and increments i.
  - after the MAC with i=j=k=N-1 (the edge at t+N^3), go to WRITE.
- WRITE:
  - at edge t+N^3+1, convert every acc element to OUT_W, load Result, set done=1, go to IDLE.
  - done stays high exactly one cycle.
- Conversion to OUT_W:
  - SAT=0: low OUT_W bits.
  - SAT=1, unsigned: clamp to 2^OUT_W-1.
  - SAT=1, signed: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Latency: start accepted at edge t -> done high after edge t+N^3+1. Default N=3: 28 cycles.
- Throughput: start is accepted in the done cycle, since state is already IDLE. Back-to-back operations therefore use N^3+1 cycles each.
- start while busy=1 is ignored; it is not queued.
- abort=1 in MAC or WRITE:
  - go to IDLE at the next edge; no done; Result keeps its previous value.
  - abort takes priority over the WRITE load.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: start wins.
- Result holds its value until the next WRITE or reset.
- done is never asserted without a completed WRITE.

Test Plan:
1. Identity, defaults (N=3, W=16, unsigned).
   - Stimulus: A=[[1,2,3],[4,5,6],[7,8,9]], B=I; 1-cycle start at edge t.
   - Required: busy high from t; done high exactly after edge t+28; Result equals A; busy low in the done cycle.
2. Square, defaults.
   - Stimulus: A=B=[[1,2,3],[4,5,6],[7,8,9]].
   - Required: Result=[[30,36,42],[66,81,96],[102,126,150]].
3. Signed saturation, N=2, W=8, OUT_W=8, SIGNED=1, SAT=1.
   - Stimulus: A=B all 127 -> required: all elements 127 (raw sum 32258).
   - Stimulus: A all -128, B all 127 -> required: all elements -128 (0x80).
4. Truncation, same parameters with SAT=0.
   - Stimulus: A=B all 127 -> required: 0x02.
   - Stimulus: A all -128, B all 127 -> required: 0x00.
5. Handshake.
   - Stimulus: pulse start again at t+5 while busy -> required: ignored; single done at t+28.
   - Stimulus: start held high in the done cycle -> required: second run accepted; its done follows exactly 28 cycles later.
6. Cancellation.
   - Stimulus: abort at t+10 -> required: IDLE at next edge, no done, Result unchanged from the prior run.
   - Stimulus: reset=0 at t+15 (asynchronous) -> required: Result=0, busy=0 immediately; no done after release.
